// File: rtl/csr_axi_lite_master.sv
// Single-outstanding command/response port bridged onto an AXI4-Lite master,
// with a per-transaction timeout that aborts a hung slave access.
module csr_axi_lite_master #(
  parameter int TIMEOUT  = 255,
  parameter int TO_WIDTH = 8
) (
  input  logic        aresetn,
  input  logic        aclk,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_resp,
  output logic        rsp_timeout,
  output logic [31:0] m_axi_awaddr,
  output logic        m_axi_awvalid,
  input  logic        m_axi_awready,
  output logic [31:0] m_axi_wdata,
  output logic [3:0]  m_axi_wstrb,
  output logic        m_axi_wvalid,
  input  logic        m_axi_wready,
  input  logic [1:0]  m_axi_bresp,
  input  logic        m_axi_bvalid,
  output logic        m_axi_bready,
  output logic [31:0] m_axi_araddr,
  output logic        m_axi_arvalid,
  input  logic        m_axi_arready,
  input  logic [31:0] m_axi_rdata,
  input  logic [1:0]  m_axi_rresp,
  input  logic        m_axi_rvalid,
  output logic        m_axi_rready
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_ADDR = 3'd1,
    ST_WR_RESP = 3'd2,
    ST_RD_ADDR = 3'd3,
    ST_RD_DATA = 3'd4,
    ST_RSP     = 3'd5
  } state_t;

  localparam logic [TO_WIDTH-1:0] TO_LAST = TO_WIDTH'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);

  state_t              state_reg, state_next;
  logic                init_done_reg;
  logic                aw_done_reg, w_done_reg;
  logic [TO_WIDTH-1:0] cnt_reg;
  logic [31:0]         addr_reg, wdata_reg, rdata_reg;
  logic [1:0]          resp_reg;
  logic                timeout_reg;

  logic cmd_fire, aw_fire, w_fire, b_fire, ar_fire, r_fire, rsp_fire;
  logic busy, expire, enter_rsp, wr_addr_done;

  assign cmd_fire  = cmd_valid & cmd_ready;
  assign aw_fire   = m_axi_awvalid & m_axi_awready;
  assign w_fire    = m_axi_wvalid & m_axi_wready;
  assign b_fire    = m_axi_bvalid & m_axi_bready;
  assign ar_fire   = m_axi_arvalid & m_axi_arready;
  assign r_fire    = m_axi_rvalid & m_axi_rready;
  assign rsp_fire  = rsp_valid & rsp_ready;

  assign busy = (state_reg == ST_WR_ADDR) || (state_reg == ST_WR_RESP) ||
                (state_reg == ST_RD_ADDR) || (state_reg == ST_RD_DATA);
  // Counter reads TIMEOUT-1 on the edge where it would reach TIMEOUT.
  assign expire = (TIMEOUT != 0) && busy && (cnt_reg == TO_LAST);
  assign wr_addr_done = (aw_done_reg | aw_fire) & (w_done_reg | w_fire);
  assign enter_rsp = (state_reg != ST_RSP) && (state_next == ST_RSP);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state_reg <= ST_IDLE;
    else          state_reg <= state_next;
  end

  // Only the final B/R handshake can beat an expiring counter.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:    if (cmd_fire) state_next = cmd_write ? ST_WR_ADDR : ST_RD_ADDR;
      ST_WR_ADDR: if (expire) state_next = ST_RSP;
                  else if (wr_addr_done) state_next = ST_WR_RESP;
      ST_WR_RESP: if (b_fire || expire) state_next = ST_RSP;
      ST_RD_ADDR: if (expire) state_next = ST_RSP;
                  else if (ar_fire) state_next = ST_RD_DATA;
      ST_RD_DATA: if (r_fire || expire) state_next = ST_RSP;
      ST_RSP:     if (rsp_fire) state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready     = 1'b0;
    m_axi_awvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    m_axi_bready  = 1'b0;
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;
    rsp_valid     = 1'b0;
    case (state_reg)
      ST_IDLE:    cmd_ready = init_done_reg;
      ST_WR_ADDR: begin
        m_axi_awvalid = ~aw_done_reg;
        m_axi_wvalid  = ~w_done_reg;
      end
      ST_WR_RESP: m_axi_bready  = 1'b1;
      ST_RD_ADDR: m_axi_arvalid = 1'b1;
      ST_RD_DATA: m_axi_rready  = 1'b1;
      ST_RSP:     rsp_valid     = 1'b1;
      default:    ;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      init_done_reg <= 1'b0;
      aw_done_reg   <= 1'b0;
      w_done_reg    <= 1'b0;
      cnt_reg       <= '0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      rdata_reg     <= '0;
      resp_reg      <= 2'b00;
      timeout_reg   <= 1'b0;
    end else begin
      init_done_reg <= 1'b1;
      if (cmd_fire) begin
        addr_reg    <= cmd_addr;
        wdata_reg   <= cmd_wdata;
        cnt_reg     <= '0;
        aw_done_reg <= 1'b0;
        w_done_reg  <= 1'b0;
      end else if (busy) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
      if (aw_fire) aw_done_reg <= 1'b1;
      if (w_fire)  w_done_reg  <= 1'b1;
      if (enter_rsp) begin
        if (b_fire) begin
          rdata_reg   <= '0;
          resp_reg    <= m_axi_bresp;
          timeout_reg <= 1'b0;
        end else if (r_fire) begin
          rdata_reg   <= m_axi_rdata;
          resp_reg    <= m_axi_rresp;
          timeout_reg <= 1'b0;
        end else begin
          rdata_reg   <= '0;
          resp_reg    <= 2'b10;
          timeout_reg <= 1'b1;
        end
      end
    end
  end

  assign m_axi_awaddr = addr_reg;
  assign m_axi_araddr = addr_reg;
  assign m_axi_wdata  = wdata_reg;
  assign m_axi_wstrb  = 4'hF;
  assign rsp_rdata    = rdata_reg;
  assign rsp_resp     = resp_reg;
  assign rsp_timeout  = timeout_reg;

  a_no_rw_overlap: assert property (@(posedge aclk) disable iff (!aresetn)
      !((m_axi_awvalid || m_axi_wvalid) && m_axi_arvalid))
    else $error("csr_axi_lite_master: write and read address channels valid together");

endmodule

// File: tb/tb_csr_axi_lite_master.sv
// Directed plus randomized bench for csr_axi_lite_master against a latency/response
// model derived from slave delays, with a configurable reactive AXI-Lite slave.
module tb_csr_axi_lite_master;
  localparam int TO = 16;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  logic        cmd_valid, cmd_ready, cmd_write, rsp_valid, rsp_ready, rsp_timeout;
  logic [31:0] cmd_addr, cmd_wdata, rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr, m_axi_rdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
  logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
  logic        m_axi_rvalid, m_axi_rready;
  logic [1:0]  m_axi_bresp, m_axi_rresp;

  csr_axi_lite_master #(.TIMEOUT(TO), .TO_WIDTH(8)) dut (
    .aresetn(aresetn), .aclk(aclk),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
    .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready), .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  // Slave configuration, written only by the stimulus block.
  int          aw_lat, w_lat, b_lat, ar_lat, r_lat;
  logic        ar_never, rvalid_inj, slv_clr;
  logic [1:0]  b_resp_cfg, r_resp_cfg;
  logic [31:0] r_data_cfg;

  int   aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
  logic aw_got, w_got, b_pend, r_pend;

  assign m_axi_awready = m_axi_awvalid && (aw_cnt >= aw_lat);
  assign m_axi_wready  = m_axi_wvalid && (w_cnt >= w_lat);
  assign m_axi_arready = m_axi_arvalid && !ar_never && (ar_cnt >= ar_lat);
  assign m_axi_bvalid  = b_pend && (b_cnt >= b_lat);
  assign m_axi_bresp   = b_resp_cfg;
  assign m_axi_rvalid  = (r_pend && (r_cnt >= r_lat)) || rvalid_inj;
  assign m_axi_rdata   = r_data_cfg;
  assign m_axi_rresp   = r_resp_cfg;

  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; b_cnt <= 0; r_cnt <= 0;
      aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b0; r_pend <= 1'b0;
    end else if (slv_clr) begin
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; b_cnt <= 0; r_cnt <= 0;
      aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b0; r_pend <= 1'b0;
    end else begin
      aw_cnt <= (m_axi_awvalid && !m_axi_awready) ? aw_cnt + 1 : 0;
      w_cnt  <= (m_axi_wvalid && !m_axi_wready) ? w_cnt + 1 : 0;
      ar_cnt <= (m_axi_arvalid && !m_axi_arready) ? ar_cnt + 1 : 0;
      if (m_axi_awvalid && m_axi_awready) aw_got <= 1'b1;
      if (m_axi_wvalid && m_axi_wready) w_got <= 1'b1;
      if ((aw_got || (m_axi_awvalid && m_axi_awready)) && (w_got || (m_axi_wvalid && m_axi_wready))) begin
        b_pend <= 1'b1; b_cnt <= 0; aw_got <= 1'b0; w_got <= 1'b0;
      end else if (m_axi_bvalid && m_axi_bready) begin
        b_pend <= 1'b0;
      end else if (b_pend) begin
        b_cnt <= b_cnt + 1;
      end
      if (m_axi_arvalid && m_axi_arready) begin
        r_pend <= 1'b1; r_cnt <= 0;
      end else if (r_pend && m_axi_rvalid && m_axi_rready) begin
        r_pend <= 1'b0;
      end else if (r_pend) begin
        r_cnt <= r_cnt + 1;
      end
    end
  end

  int compared = 0;
  int mismatched = 0;
  int awc, wc, arc, txn_no = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic set_slave(input int aw, input int w, input int b, input int ar, input int r);
    aw_lat = aw; w_lat = w; b_lat = b; ar_lat = ar; r_lat = r;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, 32'({cmd_ready, m_axi_awvalid, m_axi_wvalid, m_axi_bready,
                              m_axi_arvalid, m_axi_rready, rsp_valid, rsp_timeout, rsp_resp}), 32'h0);
    check({tag, "_awaddr"}, m_axi_awaddr, 32'h0);
    check({tag, "_araddr"}, m_axi_araddr, 32'h0);
    check({tag, "_wdata"}, m_axi_wdata, 32'h0);
    check({tag, "_rdata"}, rsp_rdata, 32'h0);
  endtask

  // One full command: issue, watch the AXI side, check the response, then consume it.
  task automatic run_txn(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                         input int hold, input bit inj);
    int d, exp_lat, lat, wait_cnt;
    bit exp_to, aw_seen, w_seen, chan_ok, order_ok, hold_ok, got_rsp;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_resp;
    if (wr) d = (aw_lat > w_lat ? aw_lat : w_lat) + b_lat;
    else    d = ar_never ? 1000 : ar_lat + r_lat;
    exp_to    = (d + 2 > TO);
    exp_lat   = exp_to ? TO + 1 : d + 3;
    exp_rdata = (wr || exp_to) ? 32'h0 : r_data_cfg;
    exp_resp  = exp_to ? 2'b10 : (wr ? b_resp_cfg : r_resp_cfg);

    @(negedge aclk);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = data;
    wait_cnt = 0;
    while (!cmd_ready && wait_cnt < 20) begin
      @(negedge aclk);
      wait_cnt++;
    end
    check("cmd_ready_seen", 32'(cmd_ready), 32'h1);
    @(posedge aclk);
    #1 cmd_valid = 1'b0;

    awc = 0; wc = 0; arc = 0; lat = 0;
    aw_seen = 0; w_seen = 0; chan_ok = 1; order_ok = 1; got_rsp = 0;
    while (!got_rsp && lat < 100) begin
      @(negedge aclk);
      lat++;
      if (rsp_valid) got_rsp = 1;
      else begin
        if (m_axi_awvalid) begin awc++; if (m_axi_awaddr !== addr) chan_ok = 0; end
        if (m_axi_wvalid) begin
          wc++;
          if (m_axi_wdata !== data || m_axi_wstrb !== 4'hF) chan_ok = 0;
        end
        if (m_axi_arvalid) begin arc++; if (m_axi_araddr !== addr) chan_ok = 0; end
        if (m_axi_bready && !(aw_seen && w_seen)) order_ok = 0;
        if (m_axi_awvalid && m_axi_awready) aw_seen = 1;
        if (m_axi_wvalid && m_axi_wready) w_seen = 1;
      end
    end
    check("rsp_latency", 32'(lat), 32'(exp_lat));
    check("rsp_rdata", rsp_rdata, exp_rdata);
    check("rsp_resp", 32'(rsp_resp), 32'(exp_resp));
    check("rsp_timeout", 32'(rsp_timeout), 32'(exp_to));
    check("axi_chan_stable", 32'(chan_ok), 32'h1);
    check("bready_after_aw_w", 32'(order_ok), 32'h1);
    check("axi_quiet_in_rsp", 32'({m_axi_awvalid, m_axi_wvalid, m_axi_bready,
                                   m_axi_arvalid, m_axi_rready, cmd_ready}), 32'h0);

    hold_ok = 1;
    for (int i = 0; i < hold; i++) begin
      rvalid_inj = inj;
      @(negedge aclk);
      if (!rsp_valid || rsp_rdata !== exp_rdata || rsp_resp !== exp_resp ||
          rsp_timeout !== exp_to || m_axi_rready || m_axi_bready || cmd_ready) hold_ok = 0;
    end
    rvalid_inj = 1'b0;
    if (hold > 0) check("rsp_hold_stable", 32'(hold_ok), 32'h1);

    rsp_ready = 1'b1;
    @(posedge aclk);
    #1 rsp_ready = 1'b0;
    @(negedge aclk);
    check("rsp_consumed", 32'(rsp_valid), 32'h0);
    check("cmd_ready_after_rsp", 32'(cmd_ready), 32'h1);
    txn_no++;
    $display("txn %0d %s addr=%h data=%h lat=%0d rdata=%h resp=%b timeout=%b",
             txn_no, wr ? "WR" : "RD", addr, data, lat, rsp_rdata, rsp_resp, rsp_timeout);
    slv_clr = 1'b1;
    @(posedge aclk);
    #1 slv_clr = 1'b0;
  endtask

  initial begin
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; rsp_ready = 1'b0;
    ar_never = 1'b0; rvalid_inj = 1'b0; slv_clr = 1'b0;
    b_resp_cfg = 2'b00; r_resp_cfg = 2'b00; r_data_cfg = 32'h0;
    set_slave(0, 0, 0, 0, 0);

    #12;
    check_all_zero("reset");
    @(negedge aclk);
    aresetn = 1'b1;
    #1 check("cmd_ready_before_edge", 32'(cmd_ready), 32'h0);
    @(posedge aclk);
    #1 check("cmd_ready_first_edge", 32'(cmd_ready), 32'h1);

    // Zero-wait write
    run_txn(1'b1, 32'h0000_0010, 32'hA5A5_5A5A, 0, 1'b0);
    check("t1_aw_cycles", 32'(awc), 32'd1);
    check("t1_w_cycles", 32'(wc), 32'd1);

    // wready delayed three cycles
    set_slave(0, 3, 0, 0, 0);
    run_txn(1'b1, 32'h0000_0020, 32'h1234_5678, 0, 1'b0);
    check("t2_aw_cycles", 32'(awc), 32'd1);
    check("t2_w_cycles", 32'(wc), 32'd4);

    // Read with two R wait cycles and response back-pressure
    set_slave(0, 0, 0, 0, 2);
    r_data_cfg = 32'hDEAD_BEEF;
    run_txn(1'b0, 32'h0000_0004, 32'h0, 5, 1'b0);
    check("t3_ar_cycles", 32'(arc), 32'd1);

    // Error responses pass through
    set_slave(0, 0, 1, 1, 0);
    b_resp_cfg = 2'b10;
    run_txn(1'b1, 32'h0000_0030, 32'hCAFE_F00D, 2, 1'b0);
    r_resp_cfg = 2'b11; r_data_cfg = 32'h0BAD_F00D;
    run_txn(1'b0, 32'h0000_0034, 32'h0, 0, 1'b0);
    b_resp_cfg = 2'b00; r_resp_cfg = 2'b00;

    // Slave never accepts AR: timeout, late rvalid ignored, next read recovers
    set_slave(0, 0, 0, 0, 0);
    ar_never = 1'b1; r_data_cfg = 32'h5555_AAAA;
    run_txn(1'b0, 32'h0000_0040, 32'h0, 3, 1'b1);
    check("t5_ar_cycles", 32'(arc), 32'(TO));
    ar_never = 1'b0;
    run_txn(1'b0, 32'h0000_0044, 32'h0, 0, 1'b0);

    // Final handshake on the expiry edge wins; one cycle later times out
    set_slave(0, 0, 0, 7, 7);
    r_data_cfg = 32'h7777_0001;
    run_txn(1'b0, 32'h0000_0050, 32'h0, 0, 1'b0);
    set_slave(0, 0, 0, 7, 8);
    run_txn(1'b0, 32'h0000_0054, 32'h0, 0, 1'b0);
    set_slave(9, 4, 5, 0, 0);
    run_txn(1'b1, 32'h0000_0058, 32'h1111_2222, 0, 1'b0);
    set_slave(9, 4, 6, 0, 0);
    run_txn(1'b1, 32'h0000_005C, 32'h3333_4444, 0, 1'b0);

    // Randomized transactions
    for (int n = 0; n < 24; n++) begin
      set_slave(int'($urandom_range(0, 8)), int'($urandom_range(0, 8)), int'($urandom_range(0, 6)),
                int'($urandom_range(0, 8)), int'($urandom_range(0, 8)));
      b_resp_cfg = 2'($urandom_range(0, 3));
      r_resp_cfg = 2'($urandom_range(0, 3));
      r_data_cfg = $urandom;
      run_txn(1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC, $urandom,
              int'($urandom_range(0, 3)), 1'b0);
    end

    // Asynchronous reset while wvalid is pending
    set_slave(0, 10, 0, 0, 0);
    @(negedge aclk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h0000_0060; cmd_wdata = 32'h9999_8888;
    @(posedge aclk);
    #1 cmd_valid = 1'b0;
    @(negedge aclk);
    check("rst_wvalid_pending", 32'(m_axi_wvalid), 32'h1);
    #2 aresetn = 1'b0;
    #1 check_all_zero("midreset");
    @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk);
    #1 check("cmd_ready_after_reset", 32'(cmd_ready), 32'h1);
    set_slave(0, 0, 0, 1, 1);
    r_data_cfg = 32'hFEED_0123;
    run_txn(1'b0, 32'h0000_0064, 32'h0, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/csr_axi_lite_master.md
Name: csr_axi_lite_master

Overview:
- Bridges a simple single-outstanding command/response port onto an AXI4-Lite master interface.
- Used by firmware-less test engines and DMA-style sequencers to drive AXI-Lite CSR slaves, such as the I2C CSR block.
- Exactly one transaction is in flight at a time. Writes and reads are serialized by construction, so no arbitration is needed.
- A per-transaction timeout guards against unresponsive slaves.

Parameters:
- TIMEOUT, 255: cycles allowed from AXI issue to B/R handshake before abort; 0 disables the timeout.
- TO_WIDTH, 8: width of the timeout counter; must satisfy TIMEOUT < 2**TO_WIDTH.

Ports:
- aresetn  in  1  asynchronous active-low reset
- aclk  in  1  clock
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when high with cmd_valid
- cmd_write  in  1  1=write, 0=read
- cmd_addr  in  32  byte address
- cmd_wdata  in  32  write data
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed
- rsp_rdata  out  32  read data (0 for writes and on timeout)
- rsp_resp  out  2  captured BRESP/RRESP; 2'b10 on timeout
- rsp_timeout  out  1  1 if the transaction was aborted by timeout
- m_axi_awaddr  out  32; m_axi_awvalid  out  1; m_axi_awready  in  1
- m_axi_wdata  out  32; m_axi_wstrb  out  4 (constant 4'hF); m_axi_wvalid  out  1; m_axi_wready  in  1
- m_axi_bresp  in  2; m_axi_bvalid  in  1; m_axi_bready  out  1
- m_axi_araddr  out  32; m_axi_arvalid  out  1; m_axi_arready  in  1
- m_axi_rdata  in  32; m_axi_rresp  in  2; m_axi_rvalid  in  1; m_axi_rready  out  1

Behaviour:
- Clocking and reset: reset aresetn, asynchronous, active-low; clock aclk.
- Reset values: every valid/ready output is 0, including cmd_ready, awvalid, wvalid, bready, arvalid, rready and rsp_valid. All addr/data outputs are 0, rsp_resp=2'b00, rsp_timeout=0, state=IDLE.
- IDLE:
  - cmd_ready=1 from the first clock edge after reset release.
  - On cmd_valid&cmd_ready: latch addr/wdata, drop cmd_ready, clear the timeout counter.
  - Go to WR_ADDR if cmd_write=1, otherwise RD_ADDR.
- WR_ADDR:
  - awvalid and wvalid are asserted together on the cycle after acceptance.
  - Each channel is tracked independently: a valid drops the cycle after its own handshake and is never re-asserted.
  - When both handshakes are done (same or different cycles), assert bready and go to WR_RESP.
- WR_RESP: on bvalid&bready, capture bresp, drop bready, set rsp_rdata=0 and rsp_timeout=0, go to RSP.
- RD_ADDR: arvalid is asserted on the cycle after acceptance. On arvalid&arready, drop arvalid, assert rready, go to RD_DATA.
- RD_DATA: on rvalid&rready, capture rdata and rresp, drop rready, set rsp_timeout=0, go to RSP.
- RSP:
  - rsp_valid=1, and all rsp_* fields are held stable while rsp_ready=0.
  - On rsp_valid&rsp_ready: drop rsp_valid, go to IDLE. cmd_ready rises the following cycle.
  - No new command is accepted in the same cycle the response is consumed.
- Latency: rsp_valid rises exactly one cycle after the final B or R handshake. With an always-ready zero-wait slave:
  - write: cmd handshake at T, AW/W valid at T+1, bready at T+2, rsp_valid at T+3 (the slave's B timing adds to this);
  - read: the same pattern through AR/R.
- Timeout (TIMEOUT≠0):
  - The counter increments every cycle in WR_ADDR, WR_RESP, RD_ADDR and RD_DATA.
  - When it reaches TIMEOUT, all AXI valids and readies drop the next cycle, and the block goes to RSP with rsp_resp=2'b10, rsp_rdata=0, rsp_timeout=1.
  - A handshake completing in the same cycle the counter reaches TIMEOUT wins; no timeout is flagged.
  - After a timeout, late bvalid/rvalid from the slave are ignored; bready/rready stay 0.
- AXI rules:
  - Address/data outputs are stable while the corresponding valid is high.
  - Valids never depend combinationally on readies.
  - The only valid-withdrawal case is a timeout abort.
- Reset mid-transaction: all outputs return to reset values immediately (asynchronously); the in-flight command is lost and no response is produced.
- Simulation-only check: report an error if awvalid or wvalid is ever asserted together with arvalid.

Test Plan:
- Write 0x0000_0010 ← 0xA5A5_5A5A, slave always ready, bresp=00 -> awaddr=0x10, wdata=0xA5A55A5A, wstrb=F on the same cycle; rsp_valid at T+3 with rsp_resp=00, rsp_timeout=0.
- Write with awready at once but wready delayed 3 cycles -> awvalid drops after 1 cycle; wvalid held 4 cycles with data stable; bready only after both handshakes; response OKAY.
- Read 0x0000_0004, slave returns 0xDEADBEEF with rresp=00 after 2 wait cycles, then hold rsp_ready=0 for 5 cycles -> rsp_rdata=0xDEADBEEF held stable; cmd_ready=0 until the cycle after rsp_ready.
- Slave returns bresp=2'b10 on a write, then rresp=2'b11 on a read -> rsp_resp=10, then 11; rsp_timeout=0 in both.
- TIMEOUT=16 with the slave never asserting arready -> arvalid drops after 16 cycles; rsp_resp=10, rsp_timeout=1, rsp_rdata=0; a later rvalid pulse is ignored and the next command completes normally.
- aresetn pulsed low while wvalid is pending -> all outputs are 0 the same cycle; after release cmd_ready=1 and a fresh read completes correctly.
